// File: rtl/token_word_packer_pkg.sv
// Shared types and default sizes for the token word packer.
package token_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int ONES_W    = $clog2(DEF_WIDTH + 1);
    localparam int PTR_W     = $clog2(DEF_DEPTH);

    // One FIFO entry: packed bits, count of '1' bits, count of valid bits.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] word;
        logic [ONES_W-1:0]    ones;
        logic [ONES_W-1:0]    len;
    } token_word_t;

endpackage

// File: rtl/token_word_packer_fifo.sv
// Synchronous FIFO of packed token words; full/empty come from an occupancy counter.
module token_word_fifo
    import token_pkg::*;
#(
    parameter type entry_t = token_word_t,
    parameter int  DEPTH   = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_fire;
    logic          push_fire;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign pop_fire  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_fire = push && (!full || pop_fire);
    assign head      = mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + AW'(1);
            if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; stale entries are never visible because reads are gated by empty.
        if (push_fire) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/token_word_packer.sv
// Packs qualified serial token bits into WIDTH-bit words, counts ones, queues words for a sink.
module token_word_packer
    import token_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_bit,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_word,
    output logic [$clog2(WIDTH+1)-1:0] out_ones,
    output logic [$clog2(WIDTH+1)-1:0] out_len,
    output logic                       overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic [CW-1:0]    ones;
        logic [CW-1:0]    len;
    } entry_t;

    logic [WIDTH-1:0]              acc_word;
    logic [CW-1:0]                 acc_idx;
    logic [CW-1:0]                 acc_ones;
    entry_t                        next_entry;
    logic                          close;
    logic                          pop;
    logic                          fifo_full;
    logic                          fifo_empty;
    entry_t                        fifo_head;
    logic [$clog2(DEPTH+1)-1:0]    fifo_count;

    // Occupancy is not needed here beyond full/empty.
    wire unused_fifo_count = ^fifo_count;

    // Accumulator contents after this cycle's bit, and whether that word closes now.
    always_comb begin
        // NOTE: every output of this block is assigned a default first, so no latch can be inferred.
        next_entry.word = acc_word;
        next_entry.ones = acc_ones + CW'(in_valid & in_bit);
        next_entry.len  = acc_idx + CW'(in_valid);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_valid && (acc_idx == CW'(i))) next_entry.word[i] = in_bit;
        end
        close = (next_entry.len == CW'(WIDTH)) || (flush && (next_entry.len != '0));
    end

    // Accumulator register: clears on close (pushed or dropped) and on reset.
    always_ff @(posedge clk) begin
        if (rst || close) begin
            acc_word <= '0;
            acc_idx  <= '0;
            acc_ones <= '0;
        end else begin
            acc_word <= next_entry.word;
            acc_idx  <= next_entry.len;
            acc_ones <= next_entry.ones;
        end
    end

    assign pop = out_valid && out_ready;

    token_word_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (close),
        .push_data (next_entry),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sticky drop flag: a closed word met a full FIFO with no pop to make room.
    always_ff @(posedge clk) begin
        if (rst)                                overflow <= 1'b0;
        else if (close && fifo_full && !pop)    overflow <= 1'b1;
    end

    assign out_valid = !fifo_empty;
    assign out_word  = fifo_empty ? '0 : fifo_head.word;
    assign out_ones  = fifo_empty ? '0 : fifo_head.ones;
    assign out_len   = fifo_empty ? '0 : fifo_head.len;

endmodule

// File: tb/tb_token_word_packer.sv
// Self-checking bench for token_word_packer (WIDTH=4, DEPTH=4).
module tb_token_word_packer;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst, in_valid, in_bit, flush, out_ready;
    logic          out_valid, overflow;
    logic [W-1:0]  out_word;
    logic [CW-1:0] out_ones, out_len;

    int tests_run = 0;
    int tests_failed = 0;

    token_word_packer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_ones  (out_ones),
        .out_len   (out_len),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural reference: a queue of completed words and a queue of pending bits.
    typedef struct {
        logic [W-1:0] word;
        int           ones;
        int           len;
    } mword_t;

    mword_t m_q[$];
    bit     m_acc[$];
    bit     m_ovf = 1'b0;
    int     tokens_pushed = 0;
    int     tokens_popped = 0;

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [W-1:0] ew,
                             input int eo, input int el, input logic eovf);
        check({tag, " valid"},    int'(out_valid), int'(ev));
        check({tag, " word"},     int'(out_word),  int'(ew));
        check({tag, " ones"},     int'(out_ones),  eo);
        check({tag, " len"},      int'(out_len),   el);
        check({tag, " overflow"}, int'(overflow),  int'(eovf));
    endtask

    function automatic void model_step(input bit r_, input bit v, input bit b, input bit f, input bit rdy);
        mword_t e;
        if (r_) begin
            m_q.delete();
            m_acc.delete();
            m_ovf = 1'b0;
            return;
        end
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (v) m_acc.push_back(b);
        if (m_acc.size() == W || (f && m_acc.size() > 0)) begin
            e.word = '0;
            e.ones = 0;
            for (int i = 0; i < m_acc.size(); i++) begin
                e.word[i] = m_acc[i];
                e.ones += int'(m_acc[i]);
            end
            e.len = m_acc.size();
            if (m_q.size() < D) begin
                m_q.push_back(e);
                tokens_pushed += e.ones;
            end else begin
                m_ovf = 1'b1;
            end
            m_acc.delete();
        end
    endfunction

    // One clock: drive inputs, record any pop, advance model, sample 1 ns after the edge.
    task automatic cycle(input logic v, input logic b, input logic f, input logic r);
        in_valid  = v;
        in_bit    = b;
        flush     = f;
        out_ready = r;
        if (out_valid && out_ready) tokens_popped += int'(out_ones);
        @(posedge clk);
        model_step(rst, v, b, f, r);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic compare_model(input string tag);
        if (m_q.size() > 0) check_out(tag, 1'b1, m_q[0].word, m_q[0].ones, m_q[0].len, m_ovf);
        else                check_out(tag, 1'b0, '0, 0, 0, m_ovf);
    endtask

    typedef struct {
        logic v, b, f, r;
        logic ev;
        logic [W-1:0] ew;
        int eo, el;
        logic eovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int pops;
        logic [W-1:0] last_word;

        rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b0;

        // Tests 1 and 2: expected values worked out by hand.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 0, 0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 0, 0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 0, 0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1101, 3, 4, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 0, 0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 0, 0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 0, 0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 2, 3, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 0, 0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 0, 0, 1'b0};

        do_reset();
        check_out("reset", 1'b0, 4'b0000, 0, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].v, vecs[i].b, vecs[i].f, vecs[i].r);
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ew, vecs[i].eo, vecs[i].el, vecs[i].eovf);
        end

        // Test 3: fill with 16 ones, 5th word is dropped, then drain exactly 4.
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0);
        check("t3 ovf after 16", int'(overflow), 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
        check("t3 ovf after 20", int'(overflow), 1);
        check("t3 valid held", int'(out_valid), 1);
        pops = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) begin
                pops++;
                check("t3 word", int'(out_word), 4'hF);
                check("t3 ones", int'(out_ones), 4);
                check("t3 len",  int'(out_len),  4);
            end
            cycle(0, 0, 0, 1);
        end
        check("t3 pop count", pops, 4);
        check("t3 ovf sticky", int'(overflow), 1);

        // Test 4: full FIFO, closing word coincides with a pop -> accepted.
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 1);
        check("t4 ovf", int'(overflow), 0);
        pops = 0;
        last_word = '0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) begin
                pops++;
                last_word = out_word;
            end
            cycle(0, 0, 0, 1);
        end
        check("t4 pop count", pops, 4);
        check("t4 last word", int'(last_word), 4'b1010);
        check("t4 ovf after", int'(overflow), 0);

        // Test 5: reset mid-word with queued words discards everything.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, i % 2, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        check("t5 queued", int'(out_valid), 1);
        rst = 1'b1;
        cycle(0, 0, 0, 0);
        rst = 1'b0;
        check_out("t5 post-rst", 1'b0, 4'b0000, 0, 0, 1'b0);
        cycle(1, 0, 0, 1);
        cycle(1, 1, 0, 1);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check_out("t5 word", 1'b1, 4'b0010, 1, 4, 1'b0);

        // Test 6: random traffic against the reference model, with token conservation.
        do_reset();
        tokens_pushed = 0;
        tokens_popped = 0;
        for (int k = 0; k < 10000; k++) begin
            logic rdy;
            rdy = ((k / 200) % 5 == 4) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
            cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0, rdy);
            compare_model("rand");
        end
        cycle(0, 0, 1, 1);
        for (int k = 0; k < 2 * D + 2; k++) cycle(0, 0, 0, 1);
        check("drain empty", int'(out_valid), 0);
        if (!m_ovf) check("token sum", tokens_popped, tokens_pushed);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
